// File: rtl/pc_gen_unit.sv
// pc_gen_unit: next-PC selection for the pipelined core.
// Holds the fetch PC and picks the next one from trap, branch, jump/call,
// return (via a circular return-address stack) or sequential fetch.
// Optional feature macro: PC_GEN_MISALIGN_TRAP_EN. When defined, a selected
// redirect target with bits [1:0] != 0 vectors to TRAP_VECTOR and pulses
// misalign_o; otherwise redirect targets are word-aligned by clearing [1:0].
module pc_gen_unit #(
    parameter int             N            = 10,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter logic [N-1:0]   TRAP_VECTOR  = N'('h3C0),
    parameter int             RAS_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          branch_taken_i,
    input  logic [31:0]   branch_target_i,
    input  logic          jump_i,
    input  logic          call_i,
    input  logic          ret_i,
    input  logic [31:0]   jump_target_i,
    input  logic          trap_i,
`ifdef PC_GEN_MISALIGN_TRAP_EN
    output logic          misalign_o,
`endif
    output logic [N-1:0]  pc_o,
    output logic [N-1:0]  pc_plus4_o,
    output logic          redirect_o,
    output logic          ras_empty_o,
    output logic          ras_full_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  pc_reg, pc_next;
    logic          redirect_reg, redirect_next;
    logic [PW-1:0] top_reg, top_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ras_empty_reg, ras_full_reg;
    logic          push, pop;
    logic          tgt_sel;
    logic [N-1:0]  tgt_raw;
    logic [N-1:0]  ras_mem [RAS_DEPTH];
    logic          mis_next;
`ifdef PC_GEN_MISALIGN_TRAP_EN
    logic          misalign_reg;
`endif

    assign pc_plus4_o = pc_reg + N'(4);

    // Priority select of the next PC plus the stack operation it implies.
    always_comb begin
        pc_next       = pc_plus4_o;
        redirect_next = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        tgt_sel       = 1'b0;
        tgt_raw       = '0;
        mis_next      = 1'b0;
        if (trap_i) begin
            pc_next       = TRAP_VECTOR;
            redirect_next = 1'b1;
        end else if (branch_taken_i) begin
            tgt_raw = branch_target_i[N-1:0];
            tgt_sel = 1'b1;
        end else if (stall_i) begin
            pc_next = pc_reg;
        end else if (jump_i) begin
            tgt_raw = jump_target_i[N-1:0];
            tgt_sel = 1'b1;
            push    = call_i;
        end else if (ret_i) begin
            // An empty stack falls back to the decoder-supplied target.
            tgt_raw = ras_empty_reg ? jump_target_i[N-1:0] : ras_mem[top_reg];
            pop     = ~ras_empty_reg;
            tgt_sel = 1'b1;
        end
        if (tgt_sel) begin
            redirect_next = 1'b1;
`ifdef PC_GEN_MISALIGN_TRAP_EN
            if (tgt_raw[1:0] != 2'b00) begin
                pc_next  = TRAP_VECTOR;
                mis_next = 1'b1;
            end else begin
                pc_next  = tgt_raw;
            end
`else
            pc_next = {tgt_raw[N-1:2], 2'b00};
`endif
        end
    end

    // Stack pointer/occupancy: a push when full overwrites the oldest entry,
    // so the count saturates while the top pointer keeps wrapping.
    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        if (push) begin
            top_next = top_reg + PW'(1);
            if (count_reg != CW'(RAS_DEPTH))
                count_next = count_reg + CW'(1);
        end else if (pop) begin
            top_next   = top_reg - PW'(1);
            count_next = count_reg - CW'(1);
        end
    end

    // PC, redirect flag and stack bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_VECTOR;
            redirect_reg  <= 1'b0;
            top_reg       <= '0;
            count_reg     <= '0;
            ras_empty_reg <= 1'b1;
            ras_full_reg  <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            redirect_reg  <= redirect_next;
            top_reg       <= top_next;
            count_reg     <= count_next;
            ras_empty_reg <= (count_next == '0);
            ras_full_reg  <= (count_next == CW'(RAS_DEPTH));
        end
    end

    // Stack entries carry no reset; the occupancy count makes them invisible.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            // Push lands at top+1, i.e. the new top.
            always_ff @(posedge clk) begin
                if (!rst && push && (top_next == PW'(gi)))
                    ras_mem[gi] <= pc_plus4_o;
            end
        end
    endgenerate

`ifdef PC_GEN_MISALIGN_TRAP_EN
    // One-cycle flag for a redirect that was replaced by the trap vector.
    always_ff @(posedge clk) begin
        if (rst) misalign_reg <= 1'b0;
        else     misalign_reg <= mis_next;
    end
    assign misalign_o = misalign_reg;
`endif

    logic unused_bits;
    assign unused_bits = ^{branch_target_i[31:N], jump_target_i[31:N], tgt_raw[1:0], mis_next};

    assign pc_o        = pc_reg;
    assign redirect_o  = redirect_reg;
    assign ras_empty_o = ras_empty_reg;
    assign ras_full_o  = ras_full_reg;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vector table, wrap and misalign sequences,
// then randomized stimulus against a queue-based reference model.
module tb_pc_gen_unit;

    localparam int N     = 10;
    localparam int DEPTH = 4;
    localparam int TRAPV = 'h3C0;
`ifdef PC_GEN_MISALIGN_TRAP_EN
    localparam int EXP_MIS = 'h3C0;
`else
    localparam int EXP_MIS = 'h120;
`endif

    logic          clk = 1'b0;
    logic          rst, stall, br, jmp, call, ret, trap;
    logic [31:0]   bt, jt;
    logic [N-1:0]  pc_o, pc_plus4_o;
    logic          redirect_o, ras_empty_o, ras_full_o;
`ifdef PC_GEN_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .N(N), .RESET_VECTOR('0), .TRAP_VECTOR(N'('h3C0)), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .branch_taken_i(br), .branch_target_i(bt),
        .jump_i(jmp), .call_i(call), .ret_i(ret), .jump_target_i(jt),
        .trap_i(trap),
`ifdef PC_GEN_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .redirect_o(redirect_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o)
    );

    typedef struct packed {
        logic        trap, br, stall, jmp, call, ret;
        logic [31:0] bt, jt;
        logic [9:0]  pc;
        logic        rd, emp, full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic t, logic b, logic s, logic j, logic c, logic r,
                                logic [31:0] btg, logic [31:0] jtg,
                                logic [9:0] pc, logic rd, logic em, logic fu);
        vec_t v;
        v.trap = t; v.br = b; v.stall = s; v.jmp = j; v.call = c; v.ret = r;
        v.bt = btg; v.jt = jtg; v.pc = pc; v.rd = rd; v.emp = em; v.full = fu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; br = 0; jmp = 0; call = 0; ret = 0; trap = 0;
        bt = 0; jt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: PC as an integer, RAS as a bounded queue.
    int   m_pc;
    int   m_q[$];
    bit   m_rd, m_mis;

    task automatic model_edge();
        int  t;
        int  p4;
        bit  sel;
        t = 0; sel = 0;
        p4 = (m_pc + 4) % 1024;
        if (rst) begin
            m_pc = 0; m_q.delete(); m_rd = 0; m_mis = 0;
        end else begin
            m_rd = 0; m_mis = 0;
            if (trap) begin
                m_pc = TRAPV; m_rd = 1;
            end else if (br) begin
                t = int'(bt); sel = 1;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (jmp) begin
                t = int'(jt); sel = 1;
                if (call) begin
                    if (m_q.size() == DEPTH) void'(m_q.pop_front());
                    m_q.push_back(p4);
                end
            end else if (ret) begin
                if (m_q.size() > 0) t = m_q.pop_back();
                else t = int'(jt);
                sel = 1;
            end else begin
                m_pc = p4;
            end
            if (sel) begin
                m_rd = 1;
                t = t & 1023;
`ifdef PC_GEN_MISALIGN_TRAP_EN
                if (t % 4 != 0) begin m_pc = TRAPV; m_mis = 1; end
                else m_pc = t;
`else
                m_pc = t & 'h3FC;
`endif
            end
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 32'($urandom_range(0, 255) * 4);
        else if (k < 8) return 32'($urandom_range(0, 1023));
        else return $urandom();
    endfunction

    initial begin
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        chk("reset_pc", 32'(pc_o), 0);
        chk("reset_redirect", 32'(redirect_o), 0);
        chk("reset_empty", 32'(ras_empty_o), 1);
        chk("reset_full", 32'(ras_full_o), 0);

        // Directed table, starting from pc=0 after reset.
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h004, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h008, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h00C, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h010, 0, 1, 0));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h100, 'h100, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h104, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h108, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 0, 'h014, 1, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h018, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h01C, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h020, 0, 1, 0));
        vecs.push_back(mk(0,0,1,1,1,0, 0, 'h200, 'h020, 0, 1, 0));
        vecs.push_back(mk(0,1,1,0,0,0, 'h080, 0, 'h080, 1, 1, 0));
        // Five calls: pushes 084(A),104(B),204(C),304(D),044(E).
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h100, 'h100, 1, 0, 0));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h200, 'h200, 1, 0, 0));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h300, 'h300, 1, 0, 0));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h040, 'h040, 1, 0, 1));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h0C0, 'h0C0, 1, 0, 1));
        // Five returns with fallback 0x300.
        vecs.push_back(mk(0,0,0,0,0,1, 0, 'h300, 'h044, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 'h300, 'h304, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 'h300, 'h204, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 'h300, 'h104, 1, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 'h300, 'h300, 1, 1, 0));
        vecs.push_back(mk(0,0,0,1,1,0, 0, 'h010, 'h010, 1, 0, 0));
        vecs.push_back(mk(1,1,0,0,0,1, 'h042, 0, 'h3C0, 1, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,1, 0, 'h050, 'h050, 1, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 0, 0, 'h054, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 0, 0, 'h304, 1, 1, 0));
        vecs.push_back(mk(0,0,0,1,0,0, 0, 'h123, 10'(EXP_MIS), 1, 1, 0));

        foreach (vecs[i]) begin
            trap = vecs[i].trap; br = vecs[i].br; stall = vecs[i].stall;
            jmp = vecs[i].jmp; call = vecs[i].call; ret = vecs[i].ret;
            bt = vecs[i].bt; jt = vecs[i].jt;
            step();
            idle_inputs();
            $display("vec %0d: pc=%h redirect=%b empty=%b full=%b", i, pc_o, redirect_o, ras_empty_o, ras_full_o);
            chk($sformatf("vec%0d_pc", i), 32'(pc_o), 32'(vecs[i].pc));
            chk($sformatf("vec%0d_redirect", i), 32'(redirect_o), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_empty", i), 32'(ras_empty_o), 32'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i), 32'(ras_full_o), 32'(vecs[i].full));
            chk($sformatf("vec%0d_plus4", i), 32'(pc_plus4_o), (32'(vecs[i].pc) + 4) & 32'h3FF);
        end

        // Sequential wrap: 255 idle edges from reset reach 0x3FC, the next wraps.
        rst = 1; step(); rst = 0;
        for (int k = 0; k < 255; k++) step();
        $display("wrap: pc=%h redirect=%b", pc_o, redirect_o);
        chk("wrap_pre_pc", 32'(pc_o), 'h3FC);
        chk("wrap_plus4", 32'(pc_plus4_o), 0);
        step();
        $display("wrap: pc=%h redirect=%b", pc_o, redirect_o);
        chk("wrap_pc", 32'(pc_o), 0);
        chk("wrap_redirect", 32'(redirect_o), 0);

`ifdef PC_GEN_MISALIGN_TRAP_EN
        br = 1; bt = 'h042; step(); idle_inputs();
        $display("misalign: pc=%h misalign=%b", pc_o, misalign_o);
        chk("mis_pc", 32'(pc_o), 'h3C0);
        chk("mis_flag", 32'(misalign_o), 1);
        step();
        $display("misalign: pc=%h misalign=%b", pc_o, misalign_o);
        chk("mis_flag_clear", 32'(misalign_o), 0);
`endif

        // Randomized phase against the reference model.
        rst = 1; model_edge(); step(); rst = 0;
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            trap  = ($urandom_range(0, 99) < 3);
            br    = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 15);
            jmp   = ($urandom_range(0, 99) < 18);
            call  = ($urandom_range(0, 1) == 1);
            ret   = ($urandom_range(0, 99) < 20);
            bt    = rand_tgt();
            jt    = rand_tgt();
            model_edge();
            step();
            chk("rnd_pc", 32'(pc_o), 32'(m_pc));
            chk("rnd_redirect", 32'(redirect_o), 32'(m_rd));
            chk("rnd_empty", 32'(ras_empty_o), 32'(m_q.size() == 0));
            chk("rnd_full", 32'(ras_full_o), 32'(m_q.size() == DEPTH));
            chk("rnd_plus4", 32'(pc_plus4_o), 32'((m_pc + 4) % 1024));
`ifdef PC_GEN_MISALIGN_TRAP_EN
            chk("rnd_misalign", 32'(misalign_o), 32'(m_mis));
`endif
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
